// File: rtl/chunked_adder_sequencer.sv
// chunked_adder_sequencer
//   Performs a W = N*K bit addition as K consecutive N-bit chunk additions,
//   least-significant chunk first. The carry passes from one chunk to the
//   next, so the full-width carry is preserved. One operation is in flight
//   at a time.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both high. in_ready is high only in IDLE and out_valid is high only
//   in DONE. While out_valid is high, sum/cout/overflow stay stable until
//   out_ready is seen.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operand pair a/b is valid
//   in_ready   block can accept an operand pair
//   a, b       W-bit addends (two's complement or unsigned)
//   out_valid  sum/cout/overflow are valid
//   out_ready  downstream accepts the result
//   sum        (a + b) mod 2^W
//   cout       unsigned carry out of bit W-1
//   overflow   signed overflow of the W-bit add
module chunked_adder_sequencer #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*K-1:0] a,
    input  logic [N*K-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*K-1:0] sum,
    output logic           cout,
    output logic           overflow
);

    localparam int W  = N * K;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    work;
    logic [W-1:0]    work_next;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [N-1:0]    a_chunk;
    logic [N-1:0]    b_chunk;
    logic [N:0]      chunk_sum;
    logic            last_chunk;
    int              base;

    // Chunk datapath: one (N+1)-bit add per cycle on the chunk selected by idx.
    always_comb begin
        base       = int'(idx) * N;
        a_chunk    = a_q[base +: N];
        b_chunk    = b_q[base +: N];
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{N{1'b0}}, carry};
        last_chunk = (idx == IW'(K - 1));
        // The final result must include the chunk produced in this cycle.
        work_next  = work;
        work_next[base +: N] = chunk_sum[N-1:0];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_chunk) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, chunk sequencing and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            work     <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        work  <= '0;
                        idx   <= '0;
                        carry <= 1'b0;
                    end
                end
                RUN: begin
                    work  <= work_next;
                    carry <= chunk_sum[N];
                    if (last_chunk) begin
                        // idx returns to 0 so it never passes K-1.
                        idx      <= '0;
                        sum      <= work_next;
                        cout     <= chunk_sum[N];
                        overflow <= (a_q[W-1] & b_q[W-1] & ~chunk_sum[N-1]) |
                                    (~a_q[W-1] & ~b_q[W-1] & chunk_sum[N-1]);
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_adder_sequencer.sv
// Testbench for chunked_adder_sequencer: a 32-bit instance (N=8, K=4) and a
// degenerate 8-bit instance (N=8, K=1), checked against an arithmetic model.
module tb_chunked_adder_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (N=8, K=4) ----------------
    logic        in_valid, in_ready, out_valid, out_ready, cout, overflow;
    logic [31:0] a, b, sum;

    chunked_adder_sequencer #(.N(8), .K(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow)
    );

    // ---------------- degenerate DUT (N=8, K=1) ----------------
    logic       in_valid1, in_ready1, out_valid1, out_ready1, cout1, overflow1;
    logic [7:0] a1, b1, sum1;

    chunked_adder_sequencer #(.N(8), .K(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .overflow(overflow1)
    );

    // ---------------- scoreboard ----------------
    int tests  = 0;
    int failed = 0;
    logic [33:0] exp_q[$];     // {overflow, cout, sum}
    logic [31:0] pend_a[$];
    logic [31:0] pend_b[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: w-bit add done in plain 64-bit integer arithmetic.
    function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv, input int w);
        longint one = 1;
        longint ua, ub, full, sa, sb, ss;
        logic [63:0] s;
        logic c, v;
        ua   = longint'({32'b0, av});
        ub   = longint'({32'b0, bv});
        full = ua + ub;
        s    = 64'(full & ((one << w) - 1));
        c    = ((full >> w) & 1) != 0;
        sa   = av[w-1] ? ua - (one << w) : ua;
        sb   = bv[w-1] ? ub - (one << w) : ub;
        ss   = sa + sb;
        v    = (ss > (one << (w - 1)) - 1) || (ss < -(one << (w - 1)));
        return {v, c, s[31:0]};
    endfunction

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input int hold);
        logic [33:0] e;
        int cnt;
        e = model(av, bv, 32);
        check("accept_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; a = av; b = bv; out_ready = 1'b0;
        @(posedge clk);               // accept edge (edge 0)
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); @(negedge clk);
            cnt++;
        end
        check("latency", 64'(cnt), 64'd4);
        check("result", 64'({overflow, cout, sum}), 64'(e));
        check("done_in_ready", 64'(in_ready), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            check("hold_stable", 64'({out_valid, in_ready, overflow, cout, sum}), 64'({2'b10, e}));
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("consume_idle", 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    task automatic run_op1(input logic [7:0] av, input logic [7:0] bv);
        logic [33:0] e;
        int cnt;
        e = model({24'b0, av}, {24'b0, bv}, 8);
        check("k1_in_ready", 64'(in_ready1), 64'd1);
        in_valid1 = 1'b1; a1 = av; b1 = bv; out_ready1 = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid1 = 1'b0;
        cnt = 0;
        while (!out_valid1 && cnt < 20) begin
            @(posedge clk); @(negedge clk);
            cnt++;
        end
        check("k1_latency", 64'(cnt), 64'd1);
        check("k1_result", 64'({overflow1, cout1, sum1}), 64'({e[33:32], e[7:0]}));
        out_ready1 = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready1 = 1'b0;
        check("k1_consume", 64'({out_valid1, in_ready1}), 64'(2'b01));
    endtask

    // Streams pend_a/pend_b through the main DUT, scoring every result.
    task automatic run_stream(input int max_cycles, input bit rnd, output int n_out);
        logic [33:0] got;
        n_out = 0;
        for (int c = 0; c < max_cycles; c++) begin
            if (pend_a.size() == 0 && exp_q.size() == 0) break;
            in_valid  = (pend_a.size() != 0) && (!rnd || $urandom_range(0, 3) != 0);
            a         = (pend_a.size() != 0) ? pend_a[0] : $urandom;
            b         = (pend_b.size() != 0) ? pend_b[0] : $urandom;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check("ready_valid_excl", 64'(in_ready & out_valid), 64'd0);
            if (out_valid) begin
                got = {overflow, cout, sum};
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    check("stream_result", 64'(got), 64'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(pend_a[0], pend_b[0], 32));
                void'(pend_a.pop_front());
                void'(pend_b.pop_front());
            end
            @(posedge clk); @(negedge clk);
        end
        check("stream_drained", 64'(pend_a.size() + exp_q.size()), 64'd0);
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        bit saw_valid;
        in_valid = 0; out_ready = 0; a = '0; b = '0;
        in_valid1 = 0; out_ready1 = 0; a1 = '0; b1 = '0;

        // Reset state
        #2;
        check("rst_main", 64'({in_ready, out_valid, overflow, cout, sum}), 64'({2'b10, 34'd0}));
        check("rst_k1", 64'({in_ready1, out_valid1, overflow1, cout1, sum1}), 64'({2'b10, 10'd0}));
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Carry ripple through every chunk, signed overflow cases
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 0);
        check("tp_wrap", 64'({overflow, cout, sum}), 64'({2'b01, 32'h0}));
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 0);
        check("tp_pos_ovf", 64'({overflow, cout, sum}), 64'({2'b10, 32'h8000_0000}));
        run_op(32'h8000_0000, 32'h8000_0000, 0);
        check("tp_neg_ovf", 64'({overflow, cout, sum}), 64'({2'b11, 32'h0}));

        // Back-pressure: hold result for 10 cycles
        run_op(32'h1234_5678, 32'h0F0F_0F0F, 10);
        check("tp_hold_sum", 64'(sum), 64'h2143_6587);

        // Back-to-back with in_valid held high
        pend_a.push_back(32'h0000_0001); pend_b.push_back(32'h0000_0002);
        pend_a.push_back(32'hFFFF_FFFE); pend_b.push_back(32'h0000_0003);
        run_stream(100, 1'b0, n);
        check("b2b_count", 64'(n), 64'd2);
        check("b2b_last", 64'({overflow, cout, sum}), 64'({2'b01, 32'h1}));

        // Asynchronous reset in RUN at chunk index 2
        in_valid = 1'b1; a = 32'h0101_0101; b = 32'h0202_0202;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk);     // two RUN edges: idx now 2
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("abort_outputs", 64'({in_ready, out_valid, overflow, cout, sum}), 64'({2'b10, 34'd0}));
        #1 reset_n = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("abort_no_valid", 64'(saw_valid), 64'd0);
        run_op(32'h0000_0005, 32'h0000_0005, 0);
        check("post_abort_sum", 64'(sum), 64'h0000_000A);

        // Randomized stream with gaps and random back-pressure
        for (int i = 0; i < 30; i++) begin
            pend_a.push_back($urandom);
            pend_b.push_back((i % 5 == 0) ? ~pend_a[pend_a.size() - 1] : $urandom);
        end
        run_stream(3000, 1'b1, n);
        check("rand_count", 64'(n), 64'd30);

        // K=1 degenerate instance
        run_op1(8'h7F, 8'h01);
        check("k1_tp", 64'({overflow1, cout1, sum1}), 64'({2'b10, 8'h80}));
        for (int i = 0; i < 6; i++) begin
            run_op1(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
